// File: rtl/calc_input_fsm.sv
// rtl/calc_input_fsm.sv - debounced ENTER/UNDO buttons driving the calculator capture-step FSM

// Per-button front end: 2-flop synchronizer, debouncer, rising-edge pulse.
module calc_input_debounce #(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic        sync1;
  logic        sync2;
  logic        level;
  logic        level_d;
  logic [15:0] count;

  // Synchronize the raw button, debounce it and emit one pulse per accepted press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      count   <= 16'd0;
      pulse   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == level) begin
        count <= 16'd0;
      end else if (count == DB_CYCLES - 16'd1) begin
        // Enough consecutive disagreeing samples: accept the new level.
        level <= ~level;
        count <= 16'd0;
      end else begin
        count <= count + 16'd1;
      end
      level_d <= level;
      // Only a press (0->1 of the debounced level) is reported; release is silent.
      pulse   <= level & ~level_d;
    end
  end

endmodule

// Capture-step FSM for the operand/operation register.
module calc_input_fsm #(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_ENTER,
  input  logic       BTN_UNDO,
  output logic [1:0] STATE,
  output logic [3:0] STATE_ONEHOT,
  output logic       ENTER_PULSE,
  output logic       UNDO_PULSE,
  output logic       CALC_DONE
);

  typedef enum logic [1:0] {
    ST_A      = 2'd0,
    ST_B      = 2'd1,
    ST_OP     = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_n;
  logic [3:0] onehot_q;
  logic       done_q;

  calc_input_debounce #(.DB_CYCLES(DB_CYCLES)) u_enter (
    .clk   (CLK),
    .reset (RESET),
    .btn   (BTN_ENTER),
    .pulse (ENTER_PULSE)
  );

  calc_input_debounce #(.DB_CYCLES(DB_CYCLES)) u_undo (
    .clk   (CLK),
    .reset (RESET),
    .btn   (BTN_UNDO),
    .pulse (UNDO_PULSE)
  );

  // Next step: ENTER advances (wrapping), UNDO retreats (saturating), both together hold.
  always_comb begin
    state_n = state_q;
    if (ENTER_PULSE && !UNDO_PULSE) begin
      case (state_q)
        ST_A:      state_n = ST_B;
        ST_B:      state_n = ST_OP;
        ST_OP:     state_n = ST_RESULT;
        ST_RESULT: state_n = ST_A;
        default:   state_n = ST_A;
      endcase
    end else if (UNDO_PULSE && !ENTER_PULSE) begin
      case (state_q)
        ST_A:      state_n = ST_A;
        ST_B:      state_n = ST_A;
        ST_OP:     state_n = ST_B;
        ST_RESULT: state_n = ST_OP;
        default:   state_n = ST_A;
      endcase
    end
  end

  // State and its decoded copies are registered together so they never disagree.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_A;
      onehot_q <= 4'b0001;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      onehot_q <= 4'b0001 << state_n;
      done_q   <= (state_n == ST_RESULT);
    end
  end

  assign STATE        = state_q;
  assign STATE_ONEHOT = onehot_q;
  assign CALC_DONE    = done_q;

endmodule

// File: tb/tb_calc_input_fsm.sv
// tb/tb_calc_input_fsm.sv - table-driven bench for calc_input_fsm with DB_CYCLES=4
module tb_calc_input_fsm;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       BTN_ENTER = 1'b0;
  logic       BTN_UNDO = 1'b0;
  logic [1:0] STATE;
  logic [3:0] STATE_ONEHOT;
  logic       ENTER_PULSE;
  logic       UNDO_PULSE;
  logic       CALC_DONE;

  int vectors = 0;
  int fails = 0;

  calc_input_fsm #(.DB_CYCLES(16'd4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .BTN_ENTER    (BTN_ENTER),
    .BTN_UNDO     (BTN_UNDO),
    .STATE        (STATE),
    .STATE_ONEHOT (STATE_ONEHOT),
    .ENTER_PULSE  (ENTER_PULSE),
    .UNDO_PULSE   (UNDO_PULSE),
    .CALC_DONE    (CALC_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       enter;
    logic       undo;
    int         exp_ep;
    int         exp_up;
    int         exp_both;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[12];

  // One rising edge, then return to the falling edge for sampling/driving.
  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    BTN_ENTER = 1'b0;
    BTN_UNDO = 1'b0;
    cyc();
    cyc();
    RESET = 1'b0;
  endtask

  task automatic chk_state(input string name, input logic [1:0] exp);
    logic [3:0] oh;
    oh = 4'b0001 << exp;
    chk({name, "_state"}, int'(STATE), int'(exp));
    chk({name, "_onehot"}, int'(STATE_ONEHOT), int'(oh));
    chk({name, "_done"}, int'(CALC_DONE), (exp == 2'd3) ? 1 : 0);
  endtask

  // Hold the buttons for 'hold' edges, release, let things settle, count pulses.
  task automatic press(input logic e, input logic u, input int hold,
                       output int ep, output int up, output int both);
    ep = 0;
    up = 0;
    both = 0;
    BTN_ENTER = e;
    BTN_UNDO = u;
    for (int i = 0; i < hold + 12; i++) begin
      if (i == hold) begin
        BTN_ENTER = 1'b0;
        BTN_UNDO = 1'b0;
      end
      cyc();
      ep += int'(ENTER_PULSE);
      up += int'(UNDO_PULSE);
      both += int'(ENTER_PULSE & UNDO_PULSE);
    end
  endtask

  initial begin
    int ep, up, both;
    logic pat [8];

    vecs[0]  = '{1'b1, 1'b0, 1, 0, 0, 2'd1};
    vecs[1]  = '{1'b1, 1'b0, 1, 0, 0, 2'd2};
    vecs[2]  = '{1'b1, 1'b0, 1, 0, 0, 2'd3};
    vecs[3]  = '{1'b1, 1'b0, 1, 0, 0, 2'd0};
    vecs[4]  = '{1'b1, 1'b0, 1, 0, 0, 2'd1};
    vecs[5]  = '{1'b1, 1'b0, 1, 0, 0, 2'd2};
    vecs[6]  = '{1'b0, 1'b1, 0, 1, 0, 2'd1};
    vecs[7]  = '{1'b0, 1'b1, 0, 1, 0, 2'd0};
    vecs[8]  = '{1'b0, 1'b1, 0, 1, 0, 2'd0};
    vecs[9]  = '{1'b1, 1'b0, 1, 0, 0, 2'd1};
    vecs[10] = '{1'b1, 1'b1, 1, 1, 1, 2'd1};
    vecs[11] = '{1'b0, 1'b1, 0, 1, 0, 2'd0};

    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b0;
    pat[4] = 1'b1; pat[5] = 1'b1; pat[6] = 1'b0; pat[7] = 1'b0;

    @(negedge CLK);
    do_reset();
    chk_state("reset", 2'd0);
    chk("reset_ep", int'(ENTER_PULSE), 0);
    chk("reset_up", int'(UNDO_PULSE), 0);

    // Clean advance: exact pulse and state-update edges.
    BTN_ENTER = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      chk("adv_pulse", int'(ENTER_PULSE), (n == 7) ? 1 : 0);
      chk("adv_state", int'(STATE), (n >= 8) ? 1 : 0);
      if (n == 8) chk("adv_onehot", int'(STATE_ONEHOT), 2);
    end
    BTN_ENTER = 1'b0;
    for (int n = 0; n < 12; n++) begin
      cyc();
      chk("adv_release_ep", int'(ENTER_PULSE), 0);
    end
    chk_state("adv_after", 2'd1);

    // Table of clean presses: wrap, undo, undo-at-zero, simultaneous.
    do_reset();
    for (int v = 0; v < 12; v++) begin
      press(vecs[v].enter, vecs[v].undo, 10, ep, up, both);
      chk($sformatf("vec%0d_ep", v), ep, vecs[v].exp_ep);
      chk($sformatf("vec%0d_up", v), up, vecs[v].exp_up);
      chk($sformatf("vec%0d_both", v), both, vecs[v].exp_both);
      chk_state($sformatf("vec%0d", v), vecs[v].exp_state);
    end

    // Bounce rejection, then a clean hold.
    do_reset();
    ep = 0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) begin
        BTN_ENTER = pat[k];
        cyc();
        ep += int'(ENTER_PULSE);
      end
    end
    BTN_ENTER = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      ep += int'(ENTER_PULSE);
    end
    chk("bounce_ep", ep, 0);
    chk_state("bounce", 2'd0);
    press(1'b1, 1'b0, 10, ep, up, both);
    chk("bounce_hold_ep", ep, 1);
    chk_state("bounce_hold", 2'd1);

    // Reset in the middle of a debounce while in RESULT.
    press(1'b1, 1'b0, 10, ep, up, both);
    press(1'b1, 1'b0, 10, ep, up, both);
    chk_state("pre_rst", 2'd3);
    BTN_ENTER = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      cyc();
      chk("midrst_pre_ep", int'(ENTER_PULSE), 0);
    end
    RESET = 1'b1;
    cyc();
    chk_state("midrst", 2'd0);
    chk("midrst_ep", int'(ENTER_PULSE), 0);
    RESET = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      chk("postrst_pulse", int'(ENTER_PULSE), (n == 7) ? 1 : 0);
      chk("postrst_state", int'(STATE), (n >= 8) ? 1 : 0);
    end
    BTN_ENTER = 1'b0;
    for (int n = 0; n < 12; n++) cyc();
    chk_state("postrst_final", 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
